alu_seq16: RTL and testbench

Sequential 16-bit arithmetic unit with valid/ready handshakes on both sides, serving the same four operations and select encoding as the combinational 16-bit ALU. It is the responder end of an operation request interface: a client issues one operation, the block computes it (add/sub in one cycle, multiply/divide iteratively over 16 cycles) and returns result plus overflow flag. It replaces the 16-stage adder chain and the combinational divider with a single shared shift/add datapath for timing-constrained builds.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/mul_div_iter16.sv | 104 ++++++++++
 rtl/alu_seq16.sv | 170 +++++++++++++++++
 tb/tb_alu_seq16.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential 16-bit ALU.
// Provides the op-select encoding, the handshake FSM state type, the
// iteration count of the shared multiply/divide datapath and the
// divide-by-zero result constant.
// Optional feature macro used by the design files: ALU_SEQ_REM_EN.
package alu_seq_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int ITER_COUNT = 16;

    localparam logic [WIDTH-1:0] DIV0_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_div_iter16.sv
// mul_div_iter16: shared iterative datapath for unsigned 16x16 multiply
// (shift-add, 32-bit product) and unsigned 16/16 restoring division.
// One iteration per clock for ITER_COUNT clocks after start.
// Optional feature macro: ALU_SEQ_REM_EN (exposes the final remainder).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and begin (ignored while busy is handled by caller)
//   is_div      1 = divide, 0 = multiply (sampled with start)
//   a, b        multiplicand/dividend, multiplier/divisor
//   last        high during the final iteration cycle
//   res_next    result that the final iteration produces (valid with last)
//   ov_next     overflow flag for that result (valid with last)
//   rem_next    remainder for that result (valid with last, ALU_SEQ_REM_EN)
module mul_div_iter16
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_next,
`ifdef ALU_SEQ_REM_EN
    output logic [WIDTH-1:0] rem_next,
`endif
    output logic             ov_next
);

    logic        busy_reg;
    logic        is_div_reg;
    logic [3:0]  cnt_reg;
    // Multiply: running product. Divide: partial remainder in [16:0].
    logic [31:0] acc_reg;
    // Multiply: multiplicand shifted left by the iteration index.
    // Divide: dividend shifting out MSB-first while quotient bits shift in.
    logic [31:0] shf_reg;
    // Multiply: multiplier shifting right (bit 0 is the current bit).
    // Divide: divisor, constant.
    logic [15:0] opd_reg;

    logic [31:0] acc_next;
    logic [31:0] shf_next;
    logic [15:0] opd_next;

    logic [31:0] mul_acc;
    logic [16:0] div_trial;
    logic        div_ge;
    logic [16:0] div_rem;

    always_comb begin
        mul_acc   = acc_reg + (opd_reg[0] ? shf_reg : 32'd0);

        // Bring down the next dividend bit into the partial remainder.
        div_trial = {acc_reg[15:0], shf_reg[15]};
        div_ge    = (div_trial >= {1'b0, opd_reg});
        div_rem   = div_ge ? (div_trial - {1'b0, opd_reg}) : div_trial;

        if (is_div_reg) begin
            acc_next = {15'd0, div_rem};
            shf_next = {16'd0, shf_reg[14:0], div_ge};
            opd_next = opd_reg;
        end else begin
            acc_next = mul_acc;
            shf_next = {shf_reg[30:0], 1'b0};
            opd_next = {1'b0, opd_reg[15:1]};
        end
    end

    assign last     = busy_reg && (cnt_reg == 4'(ITER_COUNT - 1));
    assign res_next = is_div_reg ? shf_next[15:0] : acc_next[15:0];
    assign ov_next  = !is_div_reg && (acc_next[31:16] != 16'd0);
`ifdef ALU_SEQ_REM_EN
    assign rem_next = is_div_reg ? acc_next[15:0] : 16'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            cnt_reg    <= 4'd0;
            acc_reg    <= 32'd0;
            shf_reg    <= 32'd0;
            opd_reg    <= 16'd0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            is_div_reg <= is_div;
            cnt_reg    <= 4'd0;
            acc_reg    <= 32'd0;
            shf_reg    <= {16'd0, a};
            opd_reg    <= b;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            shf_reg <= shf_next;
            opd_reg <= opd_next;
            cnt_reg <= cnt_reg + 4'd1;
            if (last) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq16.sv
// alu_seq16: sequential 16-bit ALU with valid/ready request and result
// handshakes. Add/sub complete at the accept edge; multiply/divide run
// 16 iterations on the shared mul_div_iter16 datapath.
// Optional feature macro: ALU_SEQ_REM_EN (adds the rem output port).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready only in IDLE)
//   a, b, sel           operands and op (00 add, 01 sub, 10 mul, 11 div)
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   out, ov             result and overflow/error flag (registered)
//   rem                 division remainder (ALU_SEQ_REM_EN only)
module alu_seq16
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
`ifdef ALU_SEQ_REM_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic             ov
);

    state_t state_reg;
    state_t state_next;

    logic [15:0] out_reg;
    logic        ov_reg;
    logic        load;
    logic [15:0] res_d;
    logic        ov_d;
`ifdef ALU_SEQ_REM_EN
    logic [15:0] rem_reg;
    logic [15:0] rem_d;
    logic [15:0] md_rem;
`endif

    logic        md_start;
    logic        md_last;
    logic [15:0] md_res;
    logic        md_ov;

    logic [16:0] add_sum;
    logic [16:0] sub_sum;
    logic [15:0] sub_low;

    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
        // Sum of the low 15 bits; bit 15 is the carry into the sign bit.
        sub_low = {1'b0, a[14:0]} + {1'b0, ~b[14:0]} + 16'd1;
    end

    mul_div_iter16 u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (md_start),
        .is_div   (sel == OP_DIV),
        .a        (a),
        .b        (b),
        .last     (md_last),
        .res_next (md_res),
`ifdef ALU_SEQ_REM_EN
        .rem_next (md_rem),
`endif
        .ov_next  (md_ov)
    );

    always_comb begin
        state_next = state_reg;
        md_start   = 1'b0;
        load       = 1'b0;
        res_d      = 16'd0;
        ov_d       = 1'b0;
`ifdef ALU_SEQ_REM_EN
        rem_d      = 16'd0;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    case (sel)
                        OP_ADD: begin
                            load       = 1'b1;
                            res_d      = add_sum[15:0];
                            ov_d       = add_sum[16];
                            state_next = DONE;
                        end
                        OP_SUB: begin
                            load       = 1'b1;
                            res_d      = sub_sum[15:0];
                            ov_d       = sub_low[15] ^ sub_sum[16];
                            state_next = DONE;
                        end
                        OP_MUL: begin
                            md_start   = 1'b1;
                            state_next = BUSY;
                        end
                        default: begin
                            if (b == 16'd0) begin
                                load       = 1'b1;
                                res_d      = DIV0_RESULT;
                                ov_d       = 1'b1;
`ifdef ALU_SEQ_REM_EN
                                rem_d      = a;
`endif
                                state_next = DONE;
                            end else begin
                                md_start   = 1'b1;
                                state_next = BUSY;
                            end
                        end
                    endcase
                end
            end
            BUSY: begin
                if (md_last) begin
                    load       = 1'b1;
                    res_d      = md_res;
                    ov_d       = md_ov;
`ifdef ALU_SEQ_REM_EN
                    rem_d      = md_rem;
`endif
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            out_reg   <= 16'd0;
            ov_reg    <= 1'b0;
`ifdef ALU_SEQ_REM_EN
            rem_reg   <= 16'd0;
`endif
        end else begin
            state_reg <= state_next;
            if (load) begin
                out_reg <= res_d;
                ov_reg  <= ov_d;
`ifdef ALU_SEQ_REM_EN
                rem_reg <= rem_d;
`endif
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign ov        = ov_reg;
`ifdef ALU_SEQ_REM_EN
    assign rem       = rem_reg;
`endif

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: scoreboard bench for alu_seq16. Expected results come from
// plain integer arithmetic and are queued when a request is issued, then
// popped and compared when the result handshake completes.
// Optional feature macro: ALU_SEQ_REM_EN (also checks rem).
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic [1:0]  sel = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        ov;
`ifdef ALU_SEQ_REM_EN
    logic [15:0] rem;
`endif

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
`ifdef ALU_SEQ_REM_EN
        .rem       (rem),
`endif
        .ov        (ov)
    );

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic [15:0] rmd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
        exp_t e;
        int   sx;
        int   sy;
        int   sd;
        e.rmd = 16'd0;
        e.lat = 1;
        case (op)
            2'b00: begin
                e.res = 16'((int'(x) + int'(y)) % 65536);
                e.ovf = (int'(x) + int'(y)) > 65535;
            end
            2'b01: begin
                sx = int'($signed(x));
                sy = int'($signed(y));
                sd = sx - sy;
                e.res = 16'((int'(x) - int'(y) + 65536) % 65536);
                e.ovf = (sd > 32767) || (sd < -32768);
            end
            2'b10: begin
                e.res = 16'((longint'(x) * longint'(y)) % 65536);
                e.ovf = (longint'(x) * longint'(y)) > 65535;
                e.lat = 17;
            end
            default: begin
                if (y == 16'd0) begin
                    e.res = 16'hFFFF;
                    e.ovf = 1'b1;
                    e.rmd = x;
                end else begin
                    e.res = x / y;
                    e.ovf = 1'b0;
                    e.rmd = x % y;
                    e.lat = 17;
                end
            end
        endcase
        return e;
    endfunction

    // Present a request at the next negedge and hold it until accepted.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = x;
        b = y;
        sel = op;
        in_valid = 1'b1;
        sb_q.push_back(model(x, y, op));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and the queued expectation, then pop.
    task automatic collect(input string tag, input int hold_cycles);
        exp_t e;
        int   k;
        bit   seen;
        logic [15:0] held_out;
        logic        held_ov;
        seen = 1'b0;
        k = 0;
        e = sb_q.pop_front();
        while (!seen && k < 40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else k++;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_lat"}, 32'(k + 1), 32'(e.lat));
        check({tag, "_out"}, 32'(out), 32'(e.res));
        check({tag, "_ov"}, 32'(ov), 32'(e.ovf));
`ifdef ALU_SEQ_REM_EN
        check({tag, "_rem"}, 32'(rem), 32'(e.rmd));
`endif
        held_out = out;
        held_ov  = ov;
        // Back-pressure: result must be held while a new request is offered.
        if (hold_cycles > 0) begin
            a = 16'h1234;
            b = 16'h0002;
            sel = 2'b00;
            in_valid = 1'b1;
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_out"}, 32'({out, ov}), 32'({held_out, held_ov}));
                check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_pop_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_pop_valid"}, 32'(out_valid), 32'd0);
        $display("op %s a=%0d b=%0d sel=%0d out=%0h ov=%0d lat=%0d", tag, a, b, sel, held_out, held_ov, k + 1);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ov", 32'(ov), 32'd0);
`ifdef ALU_SEQ_REM_EN
        check("rst_rem", 32'(rem), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'hFFFF, 16'h0001, 2'b00); collect("add_wrap", 0);
        issue(16'h8000, 16'h0001, 2'b01); collect("sub_ovf", 0);
        issue(16'd5, 16'd3, 2'b01);       collect("sub_small", 0);
        issue(16'd300, 16'd200, 2'b10);   collect("mul_300x200", 0);
        issue(16'h0100, 16'h0100, 2'b10); collect("mul_ovf", 0);
        issue(16'd1000, 16'd7, 2'b11);    collect("div_1000_7", 0);
        issue(16'd1234, 16'd0, 2'b11);    collect("div_zero", 0);
        issue(16'hFFFF, 16'h0001, 2'b11); collect("div_by_one", 0);
        issue(16'hFFFF, 16'hFFFF, 2'b10); collect("mul_max", 0);

        // Back-pressure for 10 cycles, with a competing request offered.
        issue(16'd77, 16'd9, 2'b10);      collect("mul_hold", 10);
        @(negedge clk);
        check("hold_no_accept", 32'(out_valid), 32'd0);

        // A few random operations of every kind.
        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 2'(i % 4));
            collect("rand", 0);
        end

        // Reset in the middle of a divide: nothing is delivered.
        @(negedge clk);
        a = 16'd1000;
        b = 16'd7;
        sel = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) check("mid_rst_spurious", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out", 32'(out), 32'd0);
        issue(16'd3, 16'd4, 2'b10);       collect("mul_after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
